// File: rtl/cafeteira_pkg.sv
// Shared constants for the coffee machine control unit.
// Holds the state encoding (also shown on db_estado) and the error codes
// reported on cod_erro, so the datapath and the display decoder agree with the UC.
package cafeteira_pkg;

    typedef enum logic [4:0] {
        StInicial        = 5'd0,
        StPrepara        = 5'd1,
        StEsperaModo     = 5'd3,
        StPrepAgua       = 5'd4,
        StAtivaAgua      = 5'd5,
        StEsperaAgua     = 5'd6,
        StErro           = 5'd7,
        StPrepXicara     = 5'd8,
        StAtivaXicara    = 5'd9,
        StEsperaXicara   = 5'd10,
        StAtivaBomba     = 5'd12,
        StEsperaBomba    = 5'd13,
        StAtivaEbulidor  = 5'd14,
        StAtivaValvula   = 5'd16,
        StFim            = 5'd17,
        StEsperaEbulidor = 5'd18,
        StEsperaValvula  = 5'd19,
        StProximaDose    = 5'd20
    } estado_t;

    localparam logic [3:0] ErrNenhum          = 4'd0;
    localparam logic [3:0] ErrSemAgua         = 4'd1;
    localparam logic [3:0] ErrSemXicara       = 4'd2;
    localparam logic [3:0] ErrTimeoutAgua     = 4'd3;
    localparam logic [3:0] ErrTimeoutXicara   = 4'd4;
    localparam logic [3:0] ErrTimeoutBomba    = 4'd5;
    localparam logic [3:0] ErrTimeoutEbulidor = 4'd6;
    localparam logic [3:0] ErrTimeoutValvula  = 4'd7;
    localparam logic [3:0] ErrDosesInvalidas  = 4'd8;
    localparam logic [3:0] ErrCancelado       = 4'd9;

endpackage

// File: rtl/cafeteira_watchdog.sv
// Watchdog counter for the coffee machine control unit.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   zera         : clear the count
//   conta        : advance the count by one this cycle
//   limite       : terminal count (timeout length minus one)
//   expirou      : count has reached limite
module cafeteira_watchdog #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             zera,
    input  logic             conta,
    input  logic [CNT_W-1:0] limite,
    output logic             expirou
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset || zera) begin
            r_cnt <= '0;
        end else if (conta) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign expirou = (r_cnt == limite);

endmodule

// File: rtl/cafeteira_seq_uc.sv
// Multi-dose control unit for the coffee machine.
// Brews `doses` cups back to back; each dose runs water check, cup check,
// pump, boiler and valve. Owns the stage watchdogs, bounded sensor retries,
// cancel handling and a latched error code.
// Ports:
//   clock, reset              : rising-edge clock, synchronous active-high reset
//   preparar, cancelar        : start / abort requests
//   pronto_serial, doses      : dose count word from the serial front end
//   pronto_sensor_*, results  : sensor handshakes
//   fim_*                     : actuator stage completion
//   zera_*, medir_agua, verifica_xicara, liga_* : datapath commands (Moore)
//   pronto, erro, cod_erro    : completion pulse, error flag, latched cause
//   doses_restantes, db_estado: remaining doses, current state encoding
module cafeteira_seq_uc
    import cafeteira_pkg::*;
#(
    parameter int unsigned DOSE_W         = 3,
    parameter int unsigned MAX_TENTATIVAS = 3,
    parameter int unsigned T_SENSOR       = 50000,
    parameter int unsigned T_BOMBA        = 500000,
    parameter int unsigned T_EBULIDOR     = 5000000,
    parameter int unsigned T_VALVULA      = 500000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              preparar,
    input  logic              cancelar,
    input  logic              pronto_serial,
    input  logic [DOSE_W-1:0] doses,
    input  logic              pronto_sensor_agua,
    input  logic              suficiente,
    input  logic              pronto_sensor_xicara,
    input  logic              tem_xicara,
    input  logic              fim_bomba,
    input  logic              fim_ebulidor,
    input  logic              fim_valvula,
    output logic              zera_sensor_agua,
    output logic              zera_sensor_xicara,
    output logic              zera_bomba,
    output logic              zera_ebulidor,
    output logic              zera_valvula,
    output logic              zera_serial,
    output logic              medir_agua,
    output logic              verifica_xicara,
    output logic              liga_bomba,
    output logic              liga_ebulidor,
    output logic              liga_valvula,
    output logic              pronto,
    output logic              erro,
    output logic [3:0]        cod_erro,
    output logic [DOSE_W-1:0] doses_restantes,
    output logic [4:0]        db_estado
);

    localparam int unsigned T_AB  = (T_SENSOR > T_BOMBA) ? T_SENSOR : T_BOMBA;
    localparam int unsigned T_CD  = (T_EBULIDOR > T_VALVULA) ? T_EBULIDOR : T_VALVULA;
    localparam int unsigned T_MAX = (T_AB > T_CD) ? T_AB : T_CD;
    localparam int unsigned CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int unsigned RET_W = (MAX_TENTATIVAS > 0) ? $clog2(MAX_TENTATIVAS + 1) : 1;

    estado_t           r_estado, w_estado_prox;
    logic [RET_W-1:0]  r_tentativas, w_tentativas_prox;
    logic [3:0]        r_cod_erro, w_cod_erro_prox;
    logic [DOSE_W-1:0] r_doses, w_doses_prox;

    logic             w_wd_zera, w_wd_conta, w_expirou;
    logic [CNT_W-1:0] w_wd_limite;
    logic             w_pode_tentar;

    cafeteira_watchdog #(
        .CNT_W (CNT_W)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .zera    (w_wd_zera),
        .conta   (w_wd_conta),
        .limite  (w_wd_limite),
        .expirou (w_expirou)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado     <= StInicial;
            r_tentativas <= '0;
            r_cod_erro   <= ErrNenhum;
            r_doses      <= '0;
        end else begin
            r_estado     <= w_estado_prox;
            r_tentativas <= w_tentativas_prox;
            r_cod_erro   <= w_cod_erro_prox;
            r_doses      <= w_doses_prox;
        end
    end

    assign w_pode_tentar = (r_tentativas < RET_W'(MAX_TENTATIVAS));

    always_comb begin
        w_estado_prox     = r_estado;
        w_tentativas_prox = r_tentativas;
        w_cod_erro_prox   = r_cod_erro;
        w_doses_prox      = r_doses;

        case (r_estado)
            StInicial: if (preparar) w_estado_prox = StPrepara;
            StPrepara: w_estado_prox = StEsperaModo;
            StEsperaModo: begin
                if (pronto_serial) begin
                    w_doses_prox = doses;
                    if (doses == '0) begin
                        w_estado_prox   = StErro;
                        w_cod_erro_prox = ErrDosesInvalidas;
                    end else begin
                        w_estado_prox = StPrepAgua;
                    end
                end
            end
            StPrepAgua:  w_estado_prox = StAtivaAgua;
            StAtivaAgua: w_estado_prox = StEsperaAgua;
            StEsperaAgua: begin
                // A reply in the expiry cycle still counts.
                if (pronto_sensor_agua) begin
                    if (suficiente) begin
                        w_estado_prox     = StPrepXicara;
                        w_tentativas_prox = '0;
                    end else begin
                        w_estado_prox   = StErro;
                        w_cod_erro_prox = ErrSemAgua;
                    end
                end else if (w_expirou) begin
                    if (w_pode_tentar) begin
                        w_estado_prox     = StPrepAgua;
                        w_tentativas_prox = r_tentativas + RET_W'(1);
                    end else begin
                        w_estado_prox   = StErro;
                        w_cod_erro_prox = ErrTimeoutAgua;
                    end
                end
            end
            StPrepXicara:  w_estado_prox = StAtivaXicara;
            StAtivaXicara: w_estado_prox = StEsperaXicara;
            StEsperaXicara: begin
                if (pronto_sensor_xicara) begin
                    if (tem_xicara) begin
                        w_estado_prox     = StAtivaBomba;
                        w_tentativas_prox = '0;
                    end else begin
                        w_estado_prox   = StErro;
                        w_cod_erro_prox = ErrSemXicara;
                    end
                end else if (w_expirou) begin
                    if (w_pode_tentar) begin
                        w_estado_prox     = StPrepXicara;
                        w_tentativas_prox = r_tentativas + RET_W'(1);
                    end else begin
                        w_estado_prox   = StErro;
                        w_cod_erro_prox = ErrTimeoutXicara;
                    end
                end
            end
            StAtivaBomba: w_estado_prox = StEsperaBomba;
            StEsperaBomba: begin
                if (fim_bomba) begin
                    w_estado_prox = StAtivaEbulidor;
                end else if (w_expirou) begin
                    w_estado_prox   = StErro;
                    w_cod_erro_prox = ErrTimeoutBomba;
                end
            end
            StAtivaEbulidor: w_estado_prox = StEsperaEbulidor;
            StEsperaEbulidor: begin
                if (fim_ebulidor) begin
                    w_estado_prox = StAtivaValvula;
                end else if (w_expirou) begin
                    w_estado_prox   = StErro;
                    w_cod_erro_prox = ErrTimeoutEbulidor;
                end
            end
            StAtivaValvula: w_estado_prox = StEsperaValvula;
            StEsperaValvula: begin
                if (fim_valvula) begin
                    w_estado_prox = StProximaDose;
                end else if (w_expirou) begin
                    w_estado_prox   = StErro;
                    w_cod_erro_prox = ErrTimeoutValvula;
                end
            end
            StProximaDose: begin
                w_doses_prox  = r_doses - DOSE_W'(1);
                w_estado_prox = (r_doses == DOSE_W'(1)) ? StFim : StPrepAgua;
            end
            StFim:  w_estado_prox = StInicial;
            StErro: if (preparar) w_estado_prox = StPrepara;
            default: w_estado_prox = StInicial;
        endcase

        // Clearing on the edge into PREPARA means a restart from ERRO shows code 0 at once.
        if (w_estado_prox == StPrepara) begin
            w_tentativas_prox = '0;
            w_cod_erro_prox   = ErrNenhum;
        end

        // Cancel overrides everything decided above, including register updates.
        if (cancelar && (r_estado != StInicial) && (r_estado != StErro)) begin
            w_estado_prox     = StErro;
            w_cod_erro_prox   = ErrCancelado;
            w_tentativas_prox = r_tentativas;
            w_doses_prox      = r_doses;
        end
    end

    always_comb begin
        zera_sensor_agua   = 1'b0;
        zera_sensor_xicara = 1'b0;
        zera_bomba         = 1'b0;
        zera_ebulidor      = 1'b0;
        zera_valvula       = 1'b0;
        zera_serial        = 1'b0;
        medir_agua         = 1'b0;
        verifica_xicara    = 1'b0;
        liga_bomba         = 1'b0;
        liga_ebulidor      = 1'b0;
        liga_valvula       = 1'b0;
        pronto             = 1'b0;
        erro               = 1'b0;
        w_wd_zera          = 1'b0;
        w_wd_conta         = 1'b0;
        w_wd_limite        = CNT_W'(T_SENSOR - 1);

        case (r_estado)
            StPrepara: begin
                zera_sensor_agua   = 1'b1;
                zera_sensor_xicara = 1'b1;
                zera_bomba         = 1'b1;
                zera_ebulidor      = 1'b1;
                zera_valvula       = 1'b1;
                zera_serial        = 1'b1;
            end
            StPrepAgua: begin
                zera_sensor_agua = 1'b1;
                w_wd_zera        = 1'b1;
            end
            StAtivaAgua: begin
                medir_agua = 1'b1;
                w_wd_zera  = 1'b1;
            end
            StEsperaAgua: w_wd_conta = 1'b1;
            StPrepXicara: begin
                zera_sensor_xicara = 1'b1;
                w_wd_zera          = 1'b1;
            end
            StAtivaXicara: begin
                verifica_xicara = 1'b1;
                w_wd_zera       = 1'b1;
            end
            StEsperaXicara: w_wd_conta = 1'b1;
            StAtivaBomba: begin
                liga_bomba = 1'b1;
                w_wd_zera  = 1'b1;
            end
            StEsperaBomba: begin
                w_wd_conta  = 1'b1;
                w_wd_limite = CNT_W'(T_BOMBA - 1);
            end
            StAtivaEbulidor: begin
                liga_ebulidor = 1'b1;
                w_wd_zera     = 1'b1;
            end
            StEsperaEbulidor: begin
                w_wd_conta  = 1'b1;
                w_wd_limite = CNT_W'(T_EBULIDOR - 1);
            end
            StAtivaValvula: begin
                liga_valvula = 1'b1;
                w_wd_zera    = 1'b1;
            end
            StEsperaValvula: begin
                w_wd_conta  = 1'b1;
                w_wd_limite = CNT_W'(T_VALVULA - 1);
            end
            StFim:  pronto = 1'b1;
            StErro: erro   = 1'b1;
            default: ;
        endcase
    end

    assign cod_erro        = r_cod_erro;
    assign doses_restantes = r_doses;
    assign db_estado       = r_estado;

endmodule

// File: tb/tb_cafeteira_seq_uc.sv
// Directed bench for cafeteira_seq_uc with short watchdog limits.
// A background responder answers start pulses after a configurable delay.
module tb_cafeteira_seq_uc;
    import cafeteira_pkg::*;

    localparam int unsigned DW = 3;
    localparam int unsigned MT = 3;
    localparam int unsigned TS = 8;
    localparam int unsigned TB = 10;
    localparam int unsigned TE = 12;
    localparam int unsigned TV = 10;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic preparar = 1'b0;
    logic cancelar = 1'b0;
    logic pronto_serial = 1'b0;
    logic [DW-1:0] doses = '0;
    logic pronto_sensor_agua = 1'b0;
    logic suficiente = 1'b0;
    logic pronto_sensor_xicara = 1'b0;
    logic tem_xicara = 1'b0;
    logic fim_bomba = 1'b0;
    logic fim_ebulidor = 1'b0;
    logic fim_valvula = 1'b0;

    logic zera_sensor_agua, zera_sensor_xicara, zera_bomba, zera_ebulidor, zera_valvula;
    logic zera_serial, medir_agua, verifica_xicara, liga_bomba, liga_ebulidor, liga_valvula;
    logic pronto, erro;
    logic [3:0] cod_erro;
    logic [DW-1:0] doses_restantes;
    logic [4:0] db_estado;

    int checks = 0;
    int errors = 0;

    // Responder configuration: delay in cycles after the start pulse, 0 = never answer.
    int cfg_d_agua = 3, cfg_d_xic = 3, cfg_d_bomba = 3, cfg_d_ebul = 3, cfg_d_valv = 3;
    bit cfg_suf = 1'b1, cfg_tem = 1'b1;
    int cd_agua = 0, cd_xic = 0, cd_bomba = 0, cd_ebul = 0, cd_valv = 0;

    cafeteira_seq_uc #(
        .DOSE_W         (DW),
        .MAX_TENTATIVAS (MT),
        .T_SENSOR       (TS),
        .T_BOMBA        (TB),
        .T_EBULIDOR     (TE),
        .T_VALVULA      (TV)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .preparar             (preparar),
        .cancelar             (cancelar),
        .pronto_serial        (pronto_serial),
        .doses                (doses),
        .pronto_sensor_agua   (pronto_sensor_agua),
        .suficiente           (suficiente),
        .pronto_sensor_xicara (pronto_sensor_xicara),
        .tem_xicara           (tem_xicara),
        .fim_bomba            (fim_bomba),
        .fim_ebulidor         (fim_ebulidor),
        .fim_valvula          (fim_valvula),
        .zera_sensor_agua     (zera_sensor_agua),
        .zera_sensor_xicara   (zera_sensor_xicara),
        .zera_bomba           (zera_bomba),
        .zera_ebulidor        (zera_ebulidor),
        .zera_valvula         (zera_valvula),
        .zera_serial          (zera_serial),
        .medir_agua           (medir_agua),
        .verifica_xicara      (verifica_xicara),
        .liga_bomba           (liga_bomba),
        .liga_ebulidor        (liga_ebulidor),
        .liga_valvula         (liga_valvula),
        .pronto               (pronto),
        .erro                 (erro),
        .cod_erro             (cod_erro),
        .doses_restantes      (doses_restantes),
        .db_estado            (db_estado)
    );

    always #5 clock = ~clock;

    // Done/reply pulses land exactly cfg_d_* cycles after the start pulse cycle.
    always @(posedge clock) begin
        #1;
        pronto_sensor_agua   = 1'b0;
        pronto_sensor_xicara = 1'b0;
        fim_bomba            = 1'b0;
        fim_ebulidor         = 1'b0;
        fim_valvula          = 1'b0;
        if (cd_agua == 1) begin pronto_sensor_agua = 1'b1; suficiente = cfg_suf; end
        if (cd_xic == 1) begin pronto_sensor_xicara = 1'b1; tem_xicara = cfg_tem; end
        if (cd_bomba == 1) fim_bomba = 1'b1;
        if (cd_ebul == 1) fim_ebulidor = 1'b1;
        if (cd_valv == 1) fim_valvula = 1'b1;
        if (cd_agua > 0) cd_agua--;
        if (cd_xic > 0) cd_xic--;
        if (cd_bomba > 0) cd_bomba--;
        if (cd_ebul > 0) cd_ebul--;
        if (cd_valv > 0) cd_valv--;
        if (reset) begin
            cd_agua = 0; cd_xic = 0; cd_bomba = 0; cd_ebul = 0; cd_valv = 0;
        end else begin
            if (medir_agua) cd_agua = cfg_d_agua;
            if (verifica_xicara) cd_xic = cfg_d_xic;
            if (liga_bomba) cd_bomba = cfg_d_bomba;
            if (liga_ebulidor) cd_ebul = cfg_d_ebul;
            if (liga_valvula) cd_valv = cfg_d_valv;
        end
    end

    task automatic wait_state(input logic [4:0] st, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (db_estado == st) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic start_brew(input logic [DW-1:0] n);
        @(negedge clock);
        doses = n;
        pronto_serial = 1'b1;
        preparar = 1'b1;
        @(negedge clock);
        preparar = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (db_estado !== 5'd0) begin
            errors++; $display("FAIL reset_state: got %0d want 0", db_estado);
        end
        checks++;
        if ({zera_sensor_agua, zera_sensor_xicara, zera_bomba, zera_ebulidor, zera_valvula,
             zera_serial, medir_agua, verifica_xicara, liga_bomba, liga_ebulidor,
             liga_valvula, pronto, erro} !== 13'd0) begin
            errors++; $display("FAIL reset_outputs: some command output nonzero");
        end
        checks++;
        if (cod_erro !== 4'd0) begin
            errors++; $display("FAIL reset_cod_erro: got %0d want 0", cod_erro);
        end
        checks++;
        if (doses_restantes !== 3'd0) begin
            errors++; $display("FAIL reset_doses: got %0d want 0", doses_restantes);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_latency();
        int lat = 0;
        cfg_d_agua = 1; cfg_d_xic = 1; cfg_d_bomba = 1; cfg_d_ebul = 1; cfg_d_valv = 1;
        cfg_suf = 1'b1; cfg_tem = 1'b1;
        @(negedge clock);
        doses = 3'd1; pronto_serial = 1'b1; preparar = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            preparar = 1'b0;
            if (pronto) begin lat = n; break; end
        end
        checks++;
        if (lat != 16) begin
            errors++; $display("FAIL latency: got %0d cycles want 16", lat);
        end
        @(negedge clock);
        checks++;
        if (pronto !== 1'b0 || db_estado !== 5'd0) begin
            errors++; $display("FAIL pronto_pulse: pronto=%0b state=%0d want 0/0", pronto, db_estado);
        end
    endtask

    task automatic test_two_doses();
        int n_valv = 0, n_pronto = 0, npx = 0, tail = -1;
        logic [DW-1:0] seq [2];
        seq[0] = '0; seq[1] = '0;
        cfg_d_agua = 3; cfg_d_xic = 3; cfg_d_bomba = 3; cfg_d_ebul = 3; cfg_d_valv = 3;
        start_brew(3'd2);
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (liga_valvula) n_valv++;
            if (pronto) begin n_pronto++; if (tail < 0) tail = 4; end
            if (db_estado == 5'd20) begin
                if (npx < 2) seq[npx] = doses_restantes;
                npx++;
            end
            if (tail > 0) tail--;
            if (tail == 0) break;
        end
        checks++;
        if (n_valv != 2) begin errors++; $display("FAIL two_doses_valvula: got %0d want 2", n_valv); end
        checks++;
        if (n_pronto != 1) begin errors++; $display("FAIL two_doses_pronto: got %0d want 1", n_pronto); end
        checks++;
        if (npx != 2 || seq[0] !== 3'd2 || seq[1] !== 3'd1) begin
            errors++; $display("FAIL two_doses_seq: got n=%0d %0d,%0d want 2 2,1", npx, seq[0], seq[1]);
        end
        checks++;
        if (doses_restantes !== 3'd0) begin
            errors++; $display("FAIL two_doses_final: got %0d want 0", doses_restantes);
        end
        checks++;
        if (cod_erro !== 4'd0 || db_estado !== 5'd0) begin
            errors++; $display("FAIL two_doses_end: cod=%0d state=%0d want 0/0", cod_erro, db_estado);
        end
    endtask

    task automatic test_sensor_timeout();
        int n_medir = 0, nr = 0, run = 0;
        int runs [4];
        for (int k = 0; k < 4; k++) runs[k] = 0;
        cfg_d_agua = 0;
        start_brew(3'd1);
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (medir_agua) n_medir++;
            if (db_estado == 5'd6) begin
                run++;
            end else if (run > 0) begin
                if (nr < 4) runs[nr] = run;
                nr++;
                run = 0;
            end
            if (db_estado == 5'd7) break;
        end
        checks++;
        if (n_medir != 4) begin errors++; $display("FAIL timeout_medir: got %0d want 4", n_medir); end
        checks++;
        if (nr != 4) begin errors++; $display("FAIL timeout_waits: got %0d want 4", nr); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (runs[k] != TS) begin
                errors++; $display("FAIL timeout_len%0d: got %0d want %0d", k, runs[k], TS);
            end
        end
        checks++;
        if (db_estado !== 5'd7 || erro !== 1'b1 || cod_erro !== 4'd3) begin
            errors++; $display("FAIL timeout_erro: state=%0d erro=%0b cod=%0d want 7/1/3",
                               db_estado, erro, cod_erro);
        end
        cfg_d_agua = 3;
    endtask

    task automatic test_sem_xicara();
        bit flipped = 1'b0;
        bit ok;
        cfg_tem = 1'b1;
        start_brew(3'd3);
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (db_estado == 5'd20 && !flipped) begin cfg_tem = 1'b0; flipped = 1'b1; end
            if (db_estado == 5'd7) break;
        end
        checks++;
        if (db_estado !== 5'd7 || cod_erro !== 4'd2 || doses_restantes !== 3'd2) begin
            errors++; $display("FAIL xicara_erro: state=%0d cod=%0d doses=%0d want 7/2/2",
                               db_estado, cod_erro, doses_restantes);
        end
        repeat (5) @(negedge clock);
        checks++;
        if (db_estado !== 5'd7 || erro !== 1'b1 || cod_erro !== 4'd2 || doses_restantes !== 3'd2) begin
            errors++; $display("FAIL xicara_hold: state=%0d erro=%0b cod=%0d doses=%0d want 7/1/2/2",
                               db_estado, erro, cod_erro, doses_restantes);
        end
        cfg_tem = 1'b1;
        start_brew(3'd1);
        checks++;
        if (db_estado !== 5'd1) begin
            errors++; $display("FAIL xicara_restart: state=%0d want 1", db_estado);
        end
        @(negedge clock);
        checks++;
        if (db_estado !== 5'd3 || cod_erro !== 4'd0) begin
            errors++; $display("FAIL xicara_clear: state=%0d cod=%0d want 3/0", db_estado, cod_erro);
        end
        wait_state(5'd0, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL xicara_finish: state=%0d want 0", db_estado); end
    endtask

    task automatic test_ebulidor_race();
        bit ok;
        int run = 1;
        cfg_d_ebul = TE;
        start_brew(3'd1);
        wait_state(5'd18, 100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL race_reach: state=%0d want 18", db_estado); end
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (db_estado == 5'd18) run++;
            else break;
        end
        checks++;
        if (run != TE) begin errors++; $display("FAIL race_len: got %0d want %0d", run, TE); end
        checks++;
        if (db_estado !== 5'd16 || cod_erro !== 4'd0) begin
            errors++; $display("FAIL race_next: state=%0d cod=%0d want 16/0", db_estado, cod_erro);
        end
        wait_state(5'd0, 100, ok);
        checks++;
        if (!ok || cod_erro !== 4'd0) begin
            errors++; $display("FAIL race_finish: state=%0d cod=%0d want 0/0", db_estado, cod_erro);
        end
        cfg_d_ebul = 3;
    endtask

    task automatic test_cancel();
        bit found = 1'b0;
        int n_ebul = 0;
        start_brew(3'd1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (liga_ebulidor) n_ebul++;
            if (db_estado == 5'd13 && fim_bomba) begin
                found = 1'b1;
                cancelar = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL cancel_reach: state=%0d want 13 with fim_bomba", db_estado); end
        @(negedge clock);
        cancelar = 1'b0;
        checks++;
        if (db_estado !== 5'd7 || cod_erro !== 4'd9) begin
            errors++; $display("FAIL cancel_erro: state=%0d cod=%0d want 7/9", db_estado, cod_erro);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (liga_ebulidor) n_ebul++;
        end
        checks++;
        if (n_ebul != 0) begin errors++; $display("FAIL cancel_ebulidor: got %0d pulses want 0", n_ebul); end
        checks++;
        if (db_estado !== 5'd7 || doses_restantes !== 3'd1) begin
            errors++; $display("FAIL cancel_hold: state=%0d doses=%0d want 7/1", db_estado, doses_restantes);
        end
    endtask

    task automatic test_doses_zero();
        bit ok;
        start_brew(3'd0);
        wait_state(5'd7, 10, ok);
        checks++;
        if (!ok || cod_erro !== 4'd8 || doses_restantes !== 3'd0) begin
            errors++; $display("FAIL doses_zero: state=%0d cod=%0d doses=%0d want 7/8/0",
                               db_estado, cod_erro, doses_restantes);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        cfg_d_valv = 0;
        start_brew(3'd1);
        wait_state(5'd19, 100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rstmid_reach: state=%0d want 19", db_estado); end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (db_estado !== 5'd0) begin errors++; $display("FAIL rstmid_state: got %0d want 0", db_estado); end
        checks++;
        if ({zera_sensor_agua, zera_sensor_xicara, zera_bomba, zera_ebulidor, zera_valvula,
             zera_serial, medir_agua, verifica_xicara, liga_bomba, liga_ebulidor,
             liga_valvula, pronto, erro} !== 13'd0 || cod_erro !== 4'd0
            || doses_restantes !== 3'd0) begin
            errors++; $display("FAIL rstmid_outputs: cod=%0d doses=%0d want all zero",
                               cod_erro, doses_restantes);
        end
        @(negedge clock);
        checks++;
        if (db_estado !== 5'd0) begin errors++; $display("FAIL rstmid_idle: got %0d want 0", db_estado); end
        cfg_d_valv = 3;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_two_doses();
        test_sensor_timeout();
        test_sem_xicara();
        test_ebulidor_race();
        test_cancel();
        test_doses_zero();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
